// File: rtl/fu_arbiter_pkg.sv
// Shared constants and the issue-stage record for the function-unit arbiter.
package fu_arbiter_pkg;
  localparam int W       = 32;
  localparam int TW      = 4;
  localparam int REQ_EXE = 0;
  localparam int REQ_BR  = 1;
  // Status bits are kept packed as {Z,C,N,V}.
  localparam int FLAG_Z  = 3;
  localparam int FLAG_C  = 2;
  localparam int FLAG_N  = 1;
  localparam int FLAG_V  = 0;

  typedef struct packed {
    logic          valid;
    logic          owner;
    logic [W-1:0]  a;
    logic [W-1:0]  b;
    logic [4:0]    sh;
    logic [4:0]    fs;
    logic          setf;
    logic [TW-1:0] tag;
  } issue_t;
endpackage

// File: rtl/rr_arb2.sv
// Two-input round-robin arbiter; last_q remembers the most recent winner.
module rr_arb2 (
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] elig,
  output logic [1:0] gnt
);
  logic last_q, last_d;

  always_comb begin
    gnt    = elig;
    last_d = last_q;
    if (elig == 2'b11) gnt = last_q ? 2'b01 : 2'b10;
    if (gnt[0])      last_d = 1'b0;
    else if (gnt[1]) last_d = 1'b1;
  end

  // Reset as "requester 1 won last" so requester 0 takes the first tie.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) last_q <= 1'b1;
    else     last_q <= last_d;
  end
endmodule

// File: rtl/fu_arbiter.sv
// Shares one ALU/shifter between the execute stage and the branch path:
// arbitrate, register operands onto the FU, capture results and status flags.
module fu_arbiter
  import fu_arbiter_pkg::*;
(
  input  logic          CLK,
  input  logic          RESET,
  input  logic          REQ_VALID_0,
  input  logic          REQ_VALID_1,
  output logic          REQ_READY_0,
  output logic          REQ_READY_1,
  input  logic [W-1:0]  REQ_A_0,
  input  logic [W-1:0]  REQ_A_1,
  input  logic [W-1:0]  REQ_B_0,
  input  logic [W-1:0]  REQ_B_1,
  input  logic [4:0]    REQ_SH_0,
  input  logic [4:0]    REQ_SH_1,
  input  logic [4:0]    REQ_FS_0,
  input  logic [4:0]    REQ_FS_1,
  input  logic          REQ_SETF_0,
  input  logic          REQ_SETF_1,
  input  logic [TW-1:0] REQ_TAG_0,
  input  logic [TW-1:0] REQ_TAG_1,
  output logic          RSP_VALID_0,
  output logic          RSP_VALID_1,
  input  logic          RSP_READY_0,
  input  logic          RSP_READY_1,
  output logic [W-1:0]  RSP_F_0,
  output logic [W-1:0]  RSP_F_1,
  output logic [TW-1:0] RSP_TAG_0,
  output logic [TW-1:0] RSP_TAG_1,
  output logic [W-1:0]  FU_A,
  output logic [W-1:0]  FU_B,
  output logic [4:0]    FU_SH,
  output logic [4:0]    FU_FS,
  input  logic [W-1:0]  FU_F,
  input  logic          FU_Z,
  input  logic          FU_C,
  input  logic          FU_N,
  input  logic          FU_V,
  output logic          Z,
  output logic          C,
  output logic          N,
  output logic          V
);
  issue_t                iss_q, iss_d;
  logic [1:0]            rsp_v_q, rsp_v_d;
  logic [1:0][W-1:0]     rsp_f_q, rsp_f_d;
  logic [1:0][TW-1:0]    rsp_tag_q, rsp_tag_d;
  logic [3:0]            flags_q, flags_d;
  logic [1:0]            rsp_rdy, own_busy, slot_free, elig, gnt;

  assign rsp_rdy   = {RSP_READY_1, RSP_READY_0};
  assign own_busy  = {iss_q.valid & iss_q.owner, iss_q.valid & ~iss_q.owner};
  assign slot_free = (~rsp_v_q | rsp_rdy) & ~own_busy;
  assign elig      = {REQ_VALID_1, REQ_VALID_0} & slot_free;

  rr_arb2 u_arb (
    .clk  (CLK),
    .rst  (RESET),
    .elig (elig),
    .gnt  (gnt)
  );

  assign REQ_READY_0 = gnt[REQ_EXE];
  assign REQ_READY_1 = gnt[REQ_BR];

  always_comb begin
    iss_d = '0;
    if (gnt[REQ_EXE]) begin
      iss_d.valid = 1'b1;
      iss_d.owner = 1'b0;
      iss_d.a     = REQ_A_0;
      iss_d.b     = REQ_B_0;
      iss_d.sh    = REQ_SH_0;
      iss_d.fs    = REQ_FS_0;
      iss_d.setf  = REQ_SETF_0;
      iss_d.tag   = REQ_TAG_0;
    end else if (gnt[REQ_BR]) begin
      iss_d.valid = 1'b1;
      iss_d.owner = 1'b1;
      iss_d.a     = REQ_A_1;
      iss_d.b     = REQ_B_1;
      iss_d.sh    = REQ_SH_1;
      iss_d.fs    = REQ_FS_1;
      iss_d.setf  = REQ_SETF_1;
      iss_d.tag   = REQ_TAG_1;
    end
  end

  // A capture for the same requester overrides its drain on the same edge.
  always_comb begin
    rsp_v_d   = rsp_v_q & ~rsp_rdy;
    rsp_f_d   = rsp_f_q;
    rsp_tag_d = rsp_tag_q;
    flags_d   = flags_q;
    if (iss_q.valid) begin
      rsp_v_d[iss_q.owner]   = 1'b1;
      rsp_f_d[iss_q.owner]   = FU_F;
      rsp_tag_d[iss_q.owner] = iss_q.tag;
      if (iss_q.setf) flags_d = {FU_Z, FU_C, FU_N, FU_V};
    end
  end

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      iss_q     <= '0;
      rsp_v_q   <= '0;
      rsp_f_q   <= '0;
      rsp_tag_q <= '0;
      flags_q   <= '0;
    end else begin
      iss_q     <= iss_d;
      rsp_v_q   <= rsp_v_d;
      rsp_f_q   <= rsp_f_d;
      rsp_tag_q <= rsp_tag_d;
      flags_q   <= flags_d;
    end
  end

  assign FU_A  = iss_q.a;
  assign FU_B  = iss_q.b;
  assign FU_SH = iss_q.sh;
  assign FU_FS = iss_q.fs;

  assign RSP_VALID_0 = rsp_v_q[REQ_EXE];
  assign RSP_VALID_1 = rsp_v_q[REQ_BR];
  assign RSP_F_0     = rsp_f_q[REQ_EXE];
  assign RSP_F_1     = rsp_f_q[REQ_BR];
  assign RSP_TAG_0   = rsp_tag_q[REQ_EXE];
  assign RSP_TAG_1   = rsp_tag_q[REQ_BR];

  assign Z = flags_q[FLAG_Z];
  assign C = flags_q[FLAG_C];
  assign N = flags_q[FLAG_N];
  assign V = flags_q[FLAG_V];
endmodule

// File: tb/tb_fu_arbiter.sv
// Randomized bench for fu_arbiter with a transaction-level reference model
// and a small ALU standing in for the function unit.
module tb_fu_arbiter;
  import fu_arbiter_pkg::*;

  logic CLK = 1'b0;
  logic RESET;
  always #5 CLK = ~CLK;

  logic          REQ_VALID_0, REQ_VALID_1, REQ_READY_0, REQ_READY_1;
  logic [W-1:0]  REQ_A_0, REQ_A_1, REQ_B_0, REQ_B_1;
  logic [4:0]    REQ_SH_0, REQ_SH_1, REQ_FS_0, REQ_FS_1;
  logic          REQ_SETF_0, REQ_SETF_1;
  logic [TW-1:0] REQ_TAG_0, REQ_TAG_1;
  logic          RSP_VALID_0, RSP_VALID_1, RSP_READY_0, RSP_READY_1;
  logic [W-1:0]  RSP_F_0, RSP_F_1;
  logic [TW-1:0] RSP_TAG_0, RSP_TAG_1;
  logic [W-1:0]  FU_A, FU_B, FU_F;
  logic [4:0]    FU_SH, FU_FS;
  logic          FU_Z, FU_C, FU_N, FU_V, Z, C, N, V;

  fu_arbiter dut (
    .CLK(CLK), .RESET(RESET),
    .REQ_VALID_0(REQ_VALID_0), .REQ_VALID_1(REQ_VALID_1),
    .REQ_READY_0(REQ_READY_0), .REQ_READY_1(REQ_READY_1),
    .REQ_A_0(REQ_A_0), .REQ_A_1(REQ_A_1), .REQ_B_0(REQ_B_0), .REQ_B_1(REQ_B_1),
    .REQ_SH_0(REQ_SH_0), .REQ_SH_1(REQ_SH_1), .REQ_FS_0(REQ_FS_0), .REQ_FS_1(REQ_FS_1),
    .REQ_SETF_0(REQ_SETF_0), .REQ_SETF_1(REQ_SETF_1),
    .REQ_TAG_0(REQ_TAG_0), .REQ_TAG_1(REQ_TAG_1),
    .RSP_VALID_0(RSP_VALID_0), .RSP_VALID_1(RSP_VALID_1),
    .RSP_READY_0(RSP_READY_0), .RSP_READY_1(RSP_READY_1),
    .RSP_F_0(RSP_F_0), .RSP_F_1(RSP_F_1), .RSP_TAG_0(RSP_TAG_0), .RSP_TAG_1(RSP_TAG_1),
    .FU_A(FU_A), .FU_B(FU_B), .FU_SH(FU_SH), .FU_FS(FU_FS),
    .FU_F(FU_F), .FU_Z(FU_Z), .FU_C(FU_C), .FU_N(FU_N), .FU_V(FU_V),
    .Z(Z), .C(C), .N(N), .V(V)
  );

  // Function unit: fs 0 add, 1 sub, 2 xor, else shift left. Returns {F,Z,C,N,V}.
  function automatic logic [35:0] alu(input logic [31:0] a, input logic [31:0] b,
                                      input logic [4:0] sh, input logic [4:0] fs);
    logic [32:0] s;
    logic [31:0] f;
    logic        c, v;
    s = '0; c = 1'b0; v = 1'b0;
    case (fs)
      5'd0: begin s = {1'b0, a} + {1'b0, b}; f = s[31:0]; c = s[32];
                  v = (a[31] == b[31]) && (f[31] != a[31]); end
      5'd1: begin s = {1'b0, a} - {1'b0, b}; f = s[31:0]; c = s[32];
                  v = (a[31] != b[31]) && (f[31] != a[31]); end
      5'd2: f = a ^ b;
      default: f = a << sh;
    endcase
    return {f, (f == 32'd0), c, f[31], v};
  endfunction

  logic [35:0] fu_res;
  assign fu_res = alu(FU_A, FU_B, FU_SH, FU_FS);
  assign FU_F = fu_res[35:4];
  assign FU_Z = fu_res[3];
  assign FU_C = fu_res[2];
  assign FU_N = fu_res[1];
  assign FU_V = fu_res[0];

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s actual=%0h required=%0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference model: the op in flight, each requester's held result, flags.
  typedef struct {
    logic          v;
    int            owner;
    logic [31:0]   a, b;
    logic [4:0]    sh, fs;
    logic          setf;
    logic [TW-1:0] tag;
  } op_t;

  op_t           m_op;
  logic          m_sv[2];
  logic [31:0]   m_sf[2];
  logic [TW-1:0] m_st[2];
  logic [3:0]    m_fl;
  int            m_last;

  logic [1:0]    s_rdy, s_rsp_v;
  logic [31:0]   s_fu_a, s_rsp_f0, s_rsp_f1;
  logic [TW-1:0] s_tag0, s_tag1;
  logic [3:0]    s_fl;

  task automatic model_reset();
    m_op.v = 1'b0;
    for (int r = 0; r < 2; r++) begin m_sv[r] = 1'b0; m_sf[r] = '0; m_st[r] = '0; end
    m_fl = '0;
    m_last = 1;
  endtask

  task automatic cyc();
    logic [1:0] el, g, rr;
    op_t        nxt;
    logic [35:0] res;
    @(negedge CLK);
    el[0] = REQ_VALID_0 && (!m_sv[0] || RSP_READY_0) && !(m_op.v && m_op.owner == 0);
    el[1] = REQ_VALID_1 && (!m_sv[1] || RSP_READY_1) && !(m_op.v && m_op.owner == 1);
    if (el == 2'b11) g = (m_last == 1) ? 2'b01 : 2'b10;
    else             g = el;
    rr = {RSP_READY_1, RSP_READY_0};
    check("req_ready", {62'd0, REQ_READY_1, REQ_READY_0}, {62'd0, g});
    check("fu_a",  {32'd0, FU_A},  m_op.v ? {32'd0, m_op.a} : 64'd0);
    check("fu_b",  {32'd0, FU_B},  m_op.v ? {32'd0, m_op.b} : 64'd0);
    check("fu_sh", {59'd0, FU_SH}, m_op.v ? {59'd0, m_op.sh} : 64'd0);
    check("fu_fs", {59'd0, FU_FS}, m_op.v ? {59'd0, m_op.fs} : 64'd0);
    check("rsp_valid", {62'd0, RSP_VALID_1, RSP_VALID_0}, {62'd0, m_sv[1], m_sv[0]});
    if (m_sv[0]) begin
      check("rsp_f_0", {32'd0, RSP_F_0}, {32'd0, m_sf[0]});
      check("rsp_tag_0", {60'd0, RSP_TAG_0}, {60'd0, m_st[0]});
    end
    if (m_sv[1]) begin
      check("rsp_f_1", {32'd0, RSP_F_1}, {32'd0, m_sf[1]});
      check("rsp_tag_1", {60'd0, RSP_TAG_1}, {60'd0, m_st[1]});
    end
    check("flags_zcnv", {60'd0, Z, C, N, V}, {60'd0, m_fl});
    s_rdy = {REQ_READY_1, REQ_READY_0};
    s_rsp_v = {RSP_VALID_1, RSP_VALID_0};
    s_fu_a = FU_A; s_rsp_f0 = RSP_F_0; s_rsp_f1 = RSP_F_1;
    s_tag0 = RSP_TAG_0; s_tag1 = RSP_TAG_1; s_fl = {Z, C, N, V};
    nxt.v = 1'b0; nxt.owner = 0; nxt.a = '0; nxt.b = '0; nxt.sh = '0; nxt.fs = '0;
    nxt.setf = 1'b0; nxt.tag = '0;
    if (g[0]) begin
      nxt.v = 1'b1; nxt.owner = 0; nxt.a = REQ_A_0; nxt.b = REQ_B_0; nxt.sh = REQ_SH_0;
      nxt.fs = REQ_FS_0; nxt.setf = REQ_SETF_0; nxt.tag = REQ_TAG_0;
    end else if (g[1]) begin
      nxt.v = 1'b1; nxt.owner = 1; nxt.a = REQ_A_1; nxt.b = REQ_B_1; nxt.sh = REQ_SH_1;
      nxt.fs = REQ_FS_1; nxt.setf = REQ_SETF_1; nxt.tag = REQ_TAG_1;
    end
    @(posedge CLK);
    if (!RESET) begin
      res = alu(m_op.a, m_op.b, m_op.sh, m_op.fs);
      for (int r = 0; r < 2; r++) begin
        if (m_op.v && m_op.owner == r) begin
          m_sv[r] = 1'b1; m_sf[r] = res[35:4]; m_st[r] = m_op.tag;
        end else if (rr[r]) begin
          m_sv[r] = 1'b0;
        end
      end
      if (m_op.v && m_op.setf) m_fl = res[3:0];
      m_op = nxt;
      if (nxt.v) m_last = nxt.owner;
    end
    #1;
  endtask

  task automatic idle();
    REQ_VALID_0 = 0; REQ_VALID_1 = 0;
    REQ_A_0 = 0; REQ_A_1 = 0; REQ_B_0 = 0; REQ_B_1 = 0;
    REQ_SH_0 = 0; REQ_SH_1 = 0; REQ_FS_0 = 0; REQ_FS_1 = 0;
    REQ_SETF_0 = 0; REQ_SETF_1 = 0; REQ_TAG_0 = 0; REQ_TAG_1 = 0;
  endtask

  task automatic set0(input logic v, input logic [31:0] a, input logic [31:0] b,
                      input logic [4:0] fs, input logic setf, input logic [TW-1:0] tag);
    REQ_VALID_0 = v; REQ_A_0 = a; REQ_B_0 = b; REQ_SH_0 = 0;
    REQ_FS_0 = fs; REQ_SETF_0 = setf; REQ_TAG_0 = tag;
  endtask

  task automatic set1(input logic v, input logic [31:0] a, input logic [31:0] b,
                      input logic [4:0] fs, input logic setf, input logic [TW-1:0] tag);
    REQ_VALID_1 = v; REQ_A_1 = a; REQ_B_1 = b; REQ_SH_1 = 0;
    REQ_FS_1 = fs; REQ_SETF_1 = setf; REQ_TAG_1 = tag;
  endtask

  task automatic apply_reset();
    RESET = 1'b1;
    model_reset();
    cyc();
    RESET = 1'b0;
  endtask

  logic [1:0] tie_log[4];

  initial begin
    idle();
    RSP_READY_0 = 1; RSP_READY_1 = 1;
    RESET = 1'b1;
    model_reset();
    @(posedge CLK); #1;
    cyc();
    check("reset_rsp_valid", {62'd0, s_rsp_v}, 64'd0);
    check("reset_flags", {60'd0, s_fl}, 64'd0);
    RESET = 1'b0;

    // Single requester-0 add.
    set0(1, 32'd5, 32'd3, 5'd0, 1, 4'd2);
    cyc();
    check("single_accept", {62'd0, s_rdy}, 64'd1);
    idle();
    cyc();
    check("single_fu_a", {32'd0, s_fu_a}, 64'd5);
    cyc();
    check("single_rsp_v0", {63'd0, s_rsp_v[0]}, 64'd1);
    check("single_rsp_f0", {32'd0, s_rsp_f0}, 64'd8);
    check("single_tag0", {60'd0, s_tag0}, 64'd2);
    check("single_z", {63'd0, s_fl[3]}, 64'd0);
    check("single_n", {63'd0, s_fl[1]}, 64'd0);

    // Tie from reset: grants alternate 0,1,0,1.
    apply_reset();
    for (int k = 0; k < 4; k++) begin
      set0(1, k, 1, 5'd0, 0, 4'(k));
      set1(1, k, 2, 5'd0, 0, 4'(k + 8));
      cyc();
      tie_log[k] = s_rdy;
    end
    check("tie_g0", {62'd0, tie_log[0]}, 64'd1);
    check("tie_g1", {62'd0, tie_log[1]}, 64'd2);
    check("tie_g2", {62'd0, tie_log[2]}, 64'd1);
    check("tie_g3", {62'd0, tie_log[3]}, 64'd2);
    idle();
    cyc(); cyc();

    // Flags: SETF op yields 0x80000000, later non-SETF zero result keeps them.
    set0(1, 32'h7fffffff, 32'd1, 5'd0, 1, 4'd1);
    cyc();
    idle();
    set1(1, 32'd5, 32'd5, 5'd2, 0, 4'd3);
    cyc();
    idle();
    cyc(); cyc();
    check("flag_rsp_f1_zero", {32'd0, s_rsp_f1}, 64'd0);
    check("flag_n_kept", {63'd0, s_fl[1]}, 64'd1);
    check("flag_z_kept", {63'd0, s_fl[3]}, 64'd0);
    check("flag_v_kept", {63'd0, s_fl[0]}, 64'd1);

    // Backpressure on requester 1.
    RSP_READY_1 = 0;
    set0(1, 32'd1, 32'd1, 5'd0, 0, 4'd4);
    set1(1, 32'd10, 32'd20, 5'd0, 0, 4'd5);
    for (int k = 0; k < 4; k++) cyc();
    for (int k = 0; k < 3; k++) begin
      cyc();
      check("bp_ready1_low", {63'd0, s_rdy[1]}, 64'd0);
      check("bp_rsp_f1_held", {32'd0, s_rsp_f1}, 64'd30);
    end
    RSP_READY_1 = 1;
    idle();
    cyc(); cyc();

    // Reset with an op in stage 1 discards it.
    set0(1, 32'h7fffffff, 32'd1, 5'd0, 1, 4'd7);
    cyc();
    idle();
    apply_reset();
    check("rst_fu_a", {32'd0, s_fu_a}, 64'd0);
    check("rst_rsp_v", {62'd0, s_rsp_v}, 64'd0);
    cyc(); cyc();
    check("rst_no_rsp", {62'd0, s_rsp_v}, 64'd0);
    check("rst_no_flags", {60'd0, s_fl}, 64'd0);

    // Random traffic with varying drain pressure and occasional resets.
    for (int k = 0; k < 3000; k++) begin
      int bias;
      bias = ((k / 250) % 2 == 0) ? 3 : 1;
      REQ_VALID_0 = ($urandom_range(0, 3) != 0);
      REQ_VALID_1 = ($urandom_range(0, 3) != 0);
      REQ_A_0 = $urandom; REQ_A_1 = $urandom;
      REQ_B_0 = ($urandom_range(0, 7) == 0) ? REQ_A_0 : $urandom;
      REQ_B_1 = $urandom;
      REQ_SH_0 = 5'($urandom); REQ_SH_1 = 5'($urandom);
      REQ_FS_0 = 5'($urandom_range(0, 4)); REQ_FS_1 = 5'($urandom_range(0, 4));
      REQ_SETF_0 = 1'($urandom); REQ_SETF_1 = 1'($urandom);
      REQ_TAG_0 = 4'($urandom); REQ_TAG_1 = 4'($urandom);
      RSP_READY_0 = ($urandom_range(0, 3) < bias);
      RSP_READY_1 = ($urandom_range(0, 3) < bias);
      if ($urandom_range(0, 599) == 0) apply_reset();
      else cyc();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
